// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback stage.
package cpu_wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MD  = 1'b1
  } src_e;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: producer handshakes, issue/hazard queries and register-file write port.
// With WB_BYPASS_EN defined the slave also drives the byp_hit*/byp_data* outputs.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_waddr;
  logic [DATA_W-1:0] alu_wdata;
  logic              md_valid;
  logic              md_ready;
  logic [ADDR_W-1:0] md_waddr;
  logic [DATA_W-1:0] md_wdata;
  logic              issue_valid;
  logic              issue_ready;
  logic [ADDR_W-1:0] issue_waddr;
  logic              rf_wren;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] chk_raddr0;
  logic              chk_pend0;
  logic [ADDR_W-1:0] chk_raddr1;
  logic              chk_pend1;
`ifdef WB_BYPASS_EN
  logic              byp_hit0;
  logic              byp_hit1;
  logic [DATA_W-1:0] byp_data0;
  logic [DATA_W-1:0] byp_data1;
`endif

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata,
    output alu_ready,
    input  md_valid, md_waddr, md_wdata,
    output md_ready,
    input  issue_valid, issue_waddr,
    output issue_ready,
    output rf_wren, rf_waddr, rf_wdata,
    input  chk_raddr0, chk_raddr1,
    output chk_pend0, chk_pend1
`ifdef WB_BYPASS_EN
    , output byp_hit0, byp_hit1, byp_data0, byp_data1
`endif
  );

  modport master (
    output alu_valid, alu_waddr, alu_wdata,
    input  alu_ready,
    output md_valid, md_waddr, md_wdata,
    input  md_ready,
    output issue_valid, issue_waddr,
    input  issue_ready,
    input  rf_wren, rf_waddr, rf_wdata,
    output chk_raddr0, chk_raddr1,
    input  chk_pend0, chk_pend1
`ifdef WB_BYPASS_EN
    , input byp_hit0, byp_hit1, byp_data0, byp_data1
`endif
  );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Per-register pending-write counters feeding issue_ready and the hazard queries.
// With WB_BYPASS_EN the pending flag is masked for the last write landing this cycle.
module wb_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_waddr_i,
  output logic              issue_ready_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [ADDR_W-1:0] chk_raddr0_i,
  input  logic [ADDR_W-1:0] chk_raddr1_i,
  output logic              chk_pend0_o,
  output logic              chk_pend1_o
`ifdef WB_BYPASS_EN
  , output logic            byp_hit0_o
  , output logic            byp_hit1_o
`endif
);
  import cpu_wb_pkg::REG_ZERO;

  localparam int              NREG    = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             issue_fire;
  logic             pend0_raw, pend1_raw;

  assign issue_ready_o = (issue_waddr_i == REG_ZERO) || (cnt_q[issue_waddr_i] != CNT_MAX);
  assign issue_fire    = issue_valid_i && issue_ready_o && (issue_waddr_i != REG_ZERO);

  always_comb begin
    logic inc, dec;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      inc = issue_fire && (issue_waddr_i == ADDR_W'(i));
      dec = wr_en_i && (wr_addr_i == ADDR_W'(i));
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !inc && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
    // r0 is never tracked
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && wr_en_i && (cnt_q[wr_addr_i] == '0) &&
        !(issue_fire && (issue_waddr_i == wr_addr_i))) begin
      $display("wb_scoreboard: protocol error, writeback to r%0d with no pending issue", wr_addr_i);
    end
  end
`endif

  assign pend0_raw = (chk_raddr0_i != REG_ZERO) && (cnt_q[chk_raddr0_i] != '0);
  assign pend1_raw = (chk_raddr1_i != REG_ZERO) && (cnt_q[chk_raddr1_i] != '0);

`ifdef WB_BYPASS_EN
  assign byp_hit0_o  = wr_en_i && (wr_addr_i == chk_raddr0_i) && (chk_raddr0_i != REG_ZERO);
  assign byp_hit1_o  = wr_en_i && (wr_addr_i == chk_raddr1_i) && (chk_raddr1_i != REG_ZERO);
  assign chk_pend0_o = pend0_raw && !(byp_hit0_o && (cnt_q[chk_raddr0_i] == CNT_W'(1)));
  assign chk_pend1_o = pend1_raw && !(byp_hit1_o && (cnt_q[chk_raddr1_i] == CNT_W'(1)));
`else
  assign chk_pend0_o = pend0_raw;
  assign chk_pend1_o = pend1_raw;
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: round-robin between ALU and mul/div results into one registered RF write.
// Optional WB_BYPASS_EN exposes the in-flight write as a forwarding source.
module regfile_wb_arbiter #(
  parameter int DATA_W = cpu_wb_pkg::DATA_W,
  parameter int ADDR_W = cpu_wb_pkg::ADDR_W,
  parameter int CNT_W  = cpu_wb_pkg::CNT_W
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  import cpu_wb_pkg::*;

  src_e              last_grant_q, last_grant_d;
  logic              rf_wren_q, rf_wren_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              alu_gnt, md_gnt;

  // On a conflict the source that did not win last time is granted.
  always_comb begin
    alu_gnt      = bus.alu_valid && (!bus.md_valid || (last_grant_q == SRC_MD));
    md_gnt       = bus.md_valid && !alu_gnt;
    last_grant_d = last_grant_q;
    rf_wren_d    = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    if (alu_gnt) begin
      last_grant_d = SRC_ALU;
      rf_wren_d    = (bus.alu_waddr != REG_ZERO);
      rf_waddr_d   = bus.alu_waddr;
      rf_wdata_d   = bus.alu_wdata;
    end else if (md_gnt) begin
      last_grant_d = SRC_MD;
      rf_wren_d    = (bus.md_waddr != REG_ZERO);
      rf_waddr_d   = bus.md_waddr;
      rf_wdata_d   = bus.md_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= SRC_MD;
      rf_wren_q    <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_wren_q    <= rf_wren_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign bus.alu_ready = alu_gnt;
  assign bus.md_ready  = md_gnt;
  assign bus.rf_wren   = rf_wren_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;

`ifdef WB_BYPASS_EN
  assign bus.byp_data0 = rf_wdata_q;
  assign bus.byp_data1 = rf_wdata_q;
`endif

  wb_scoreboard #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_i (bus.issue_valid),
    .issue_waddr_i (bus.issue_waddr),
    .issue_ready_o (bus.issue_ready),
    .wr_en_i       (rf_wren_q),
    .wr_addr_i     (rf_waddr_q),
    .chk_raddr0_i  (bus.chk_raddr0),
    .chk_raddr1_i  (bus.chk_raddr1),
    .chk_pend0_o   (bus.chk_pend0),
    .chk_pend1_o   (bus.chk_pend1)
`ifdef WB_BYPASS_EN
    , .byp_hit0_o  (bus.byp_hit0)
    , .byp_hit1_o  (bus.byp_hit1)
`endif
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  regfile_wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: pending writes per register, who wins the next tie, and the RF write in flight.
  int            m_cnt [32];
  bit            m_alu_pref;
  bit            m_wren;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  function automatic bit exp_pend(input logic [AW-1:0] ra);
    bit p;
    p = (ra != 0) && (m_cnt[ra] != 0);
`ifdef WB_BYPASS_EN
    if (m_wren && m_waddr == ra && ra != 0 && m_cnt[ra] == 1) p = 1'b0;
`endif
    return p;
  endfunction

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_waddr = '0; bus.alu_wdata = '0;
    bus.md_valid = 1'b0;  bus.md_waddr = '0;  bus.md_wdata = '0;
    bus.issue_valid = 1'b0; bus.issue_waddr = '0;
    bus.chk_raddr0 = '0; bus.chk_raddr1 = '0;
  endtask

  // Advance one clock, updating the model from the inputs presented on that edge.
  task automatic tick();
    bit alu_go, md_go, iss_go;
    int nc [32];
    int d;
    alu_go = bus.alu_valid && (!bus.md_valid || m_alu_pref);
    md_go  = bus.md_valid && !alu_go;
    iss_go = bus.issue_valid && (bus.issue_waddr != 0) && (m_cnt[bus.issue_waddr] < 3);
    nc = m_cnt;
    for (int r = 1; r < 32; r++) begin
      d = int'(iss_go && bus.issue_waddr == r) - int'(m_wren && m_waddr == r);
      if (d > 0) nc[r]++;
      else if (d < 0 && nc[r] > 0) nc[r]--;
    end
    if (rst) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_alu_pref = 1'b1; m_wren = 1'b0; m_waddr = '0; m_wdata = '0;
    end else begin
      m_cnt = nc;
      if (alu_go) begin
        m_alu_pref = 1'b0; m_waddr = bus.alu_waddr; m_wdata = bus.alu_wdata; m_wren = (bus.alu_waddr != 0);
      end else if (md_go) begin
        m_alu_pref = 1'b1; m_waddr = bus.md_waddr; m_wdata = bus.md_wdata; m_wren = (bus.md_waddr != 0);
      end else begin
        m_wren = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_tests++; if (bus.rf_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b want 0", bus.rf_wren); end
    n_tests++; if (bus.rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d want 0", bus.rf_waddr); end
    n_tests++; if (bus.rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus.rf_wdata); end
    bus.issue_waddr = 5'd7; bus.chk_raddr0 = 5'd7; bus.chk_raddr1 = 5'd12;
    @(negedge clk);
    n_tests++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %b want 1", bus.issue_ready); end
    n_tests++; if (bus.chk_pend0 !== 1'b0 || bus.chk_pend1 !== 1'b0) begin n_fail++; $display("FAIL reset_pend: got %b%b want 00", bus.chk_pend0, bus.chk_pend1); end
    n_tests++; if (bus.alu_ready !== 1'b0 || bus.md_ready !== 1'b0) begin n_fail++; $display("FAIL reset_idle_ready: got %b%b want 00", bus.alu_ready, bus.md_ready); end
    idle_inputs();
  endtask

  task automatic test_alu_single();
    do_reset();
    bus.alu_valid = 1'b1; bus.alu_waddr = 5'd5; bus.alu_wdata = 32'h1234;
    @(negedge clk);
    n_tests++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL alu_single_ready: got %b want 1", bus.alu_ready); end
    tick();
    idle_inputs();
    n_tests++; if (bus.rf_wren !== 1'b1) begin n_fail++; $display("FAIL alu_single_wren: got %b want 1", bus.rf_wren); end
    n_tests++; if (bus.rf_waddr !== 5'd5) begin n_fail++; $display("FAIL alu_single_waddr: got %0d want 5", bus.rf_waddr); end
    n_tests++; if (bus.rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL alu_single_wdata: got %h want 00001234", bus.rf_wdata); end
    tick();
    n_tests++; if (bus.rf_wren !== 1'b0) begin n_fail++; $display("FAIL alu_single_idle_wren: got %b want 0", bus.rf_wren); end
    n_tests++; if (bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL alu_single_hold: got %0d/%h want 5/00001234", bus.rf_waddr, bus.rf_wdata); end
  endtask

  task automatic test_alternation();
    bit exp_alu;
    do_reset();
    bus.alu_valid = 1'b1; bus.alu_waddr = 5'd1; bus.alu_wdata = 32'h11;
    bus.md_valid = 1'b1;  bus.md_waddr = 5'd2;  bus.md_wdata = 32'h22;
    for (int k = 0; k < 4; k++) begin
      exp_alu = (k % 2 == 0);
      @(negedge clk);
      n_tests++; if (bus.alu_ready !== exp_alu || bus.md_ready !== !exp_alu) begin n_fail++; $display("FAIL alternation_grant[%0d]: got alu=%b md=%b want alu=%b", k, bus.alu_ready, bus.md_ready, exp_alu); end
      tick();
      n_tests++; if (bus.rf_waddr !== (exp_alu ? 5'd1 : 5'd2) || bus.rf_wren !== 1'b1) begin n_fail++; $display("FAIL alternation_waddr[%0d]: got %0d wren=%b want %0d", k, bus.rf_waddr, bus.rf_wren, exp_alu ? 1 : 2); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_issue_saturate();
    do_reset();
    bus.chk_raddr0 = 5'd7;
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL saturate_ready[%0d]: got %b want 1", k, bus.issue_ready); end
      tick();
    end
    @(negedge clk);
    n_tests++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL saturate_full: got %b want 0", bus.issue_ready); end
    n_tests++; if (bus.chk_pend0 !== 1'b1) begin n_fail++; $display("FAIL saturate_pend: got %b want 1", bus.chk_pend0); end
    tick();
    bus.issue_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_waddr = 5'd7; bus.alu_wdata = 32'h77;
    tick(); tick(); tick();
    bus.alu_valid = 1'b0;
    @(negedge clk);
`ifdef WB_BYPASS_EN
    n_tests++; if (bus.chk_pend0 !== 1'b0) begin n_fail++; $display("FAIL saturate_last_write_pend: got %b want 0", bus.chk_pend0); end
`else
    n_tests++; if (bus.chk_pend0 !== 1'b1) begin n_fail++; $display("FAIL saturate_last_write_pend: got %b want 1", bus.chk_pend0); end
`endif
    tick();
    @(negedge clk);
    n_tests++; if (bus.chk_pend0 !== 1'b0) begin n_fail++; $display("FAIL saturate_drained: got %b want 0", bus.chk_pend0); end
    idle_inputs();
  endtask

  task automatic test_r0_write();
    do_reset();
    bus.alu_valid = 1'b1; bus.alu_waddr = 5'd0; bus.alu_wdata = 32'hFFFF_FFFF;
    bus.chk_raddr0 = 5'd0;
    @(negedge clk);
    n_tests++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready: got %b want 1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    n_tests++; if (bus.rf_wren !== 1'b0) begin n_fail++; $display("FAIL r0_wren: got %b want 0", bus.rf_wren); end
    n_tests++; if (bus.rf_wdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL r0_wdata: got %h want ffffffff", bus.rf_wdata); end
    @(negedge clk);
    n_tests++; if (bus.chk_pend0 !== 1'b0) begin n_fail++; $display("FAIL r0_pend: got %b want 0", bus.chk_pend0); end
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    do_reset();
    bus.chk_raddr0 = 5'd3;
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd3;
    tick();
    bus.issue_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_waddr = 5'd3; bus.alu_wdata = 32'h33;
    tick();
    bus.alu_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd3;
    @(negedge clk);
    n_tests++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL same_cycle_ready: got %b want 1", bus.issue_ready); end
    tick();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.chk_pend0 !== 1'b1) begin n_fail++; $display("FAIL same_cycle_pend: got %b want 1", bus.chk_pend0); end
    tick();
    @(negedge clk);
    n_tests++; if (bus.chk_pend0 !== 1'b1) begin n_fail++; $display("FAIL same_cycle_pend_hold: got %b want 1", bus.chk_pend0); end
    idle_inputs();
  endtask

  task automatic test_rst_midop();
    do_reset();
    bus.chk_raddr0 = 5'd9; bus.chk_raddr1 = 5'd4;
    bus.issue_valid = 1'b1;
    bus.issue_waddr = 5'd9; tick();
    bus.issue_waddr = 5'd4; tick();
    bus.issue_waddr = 5'd9; tick();
    bus.issue_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_waddr = 5'd9; bus.alu_wdata = 32'h9999;
    tick();
    bus.alu_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.rf_wren !== 1'b1 || bus.chk_pend0 !== 1'b1 || bus.chk_pend1 !== 1'b1) begin n_fail++; $display("FAIL midop_before: got wren=%b pend=%b%b want 1 11", bus.rf_wren, bus.chk_pend0, bus.chk_pend1); end
`ifdef WB_BYPASS_EN
    n_tests++; if (bus.byp_hit0 !== 1'b1 || bus.byp_data0 !== 32'h9999) begin n_fail++; $display("FAIL midop_bypass0: got hit=%b data=%h want 1/00009999", bus.byp_hit0, bus.byp_data0); end
    n_tests++; if (bus.byp_hit1 !== 1'b0) begin n_fail++; $display("FAIL midop_bypass1: got %b want 0", bus.byp_hit1); end
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (bus.rf_wren !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0) begin n_fail++; $display("FAIL midop_rf: got wren=%b addr=%0d data=%h want 0/0/0", bus.rf_wren, bus.rf_waddr, bus.rf_wdata); end
    bus.alu_valid = 1'b1; bus.alu_waddr = 5'd1;
    bus.md_valid = 1'b1;  bus.md_waddr = 5'd2;
    @(negedge clk);
    n_tests++; if (bus.chk_pend0 !== 1'b0 || bus.chk_pend1 !== 1'b0) begin n_fail++; $display("FAIL midop_pend: got %b%b want 00", bus.chk_pend0, bus.chk_pend1); end
    n_tests++; if (bus.alu_ready !== 1'b1 || bus.md_ready !== 1'b0) begin n_fail++; $display("FAIL midop_grant: got alu=%b md=%b want alu=1 md=0", bus.alu_ready, bus.md_ready); end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.alu_valid   = $urandom_range(0, 1) == 1;
      bus.alu_waddr   = AW'($urandom_range(0, 7));
      bus.alu_wdata   = $urandom;
      bus.md_valid    = $urandom_range(0, 1) == 1;
      bus.md_waddr    = AW'($urandom_range(0, 7));
      bus.md_wdata    = $urandom;
      bus.issue_valid = $urandom_range(0, 2) != 0;
      bus.issue_waddr = AW'($urandom_range(0, 7));
      bus.chk_raddr0  = AW'($urandom_range(0, 7));
      bus.chk_raddr1  = AW'($urandom_range(0, 7));
      @(negedge clk);
      n_tests++; if (bus.alu_ready !== (bus.alu_valid && (!bus.md_valid || m_alu_pref)) ||
                     bus.md_ready !== (bus.md_valid && !(bus.alu_valid && (!bus.md_valid || m_alu_pref)))) begin
        n_fail++; $display("FAIL random_grant[%0d]: got alu=%b md=%b with valids %b%b pref_alu=%b", c, bus.alu_ready, bus.md_ready, bus.alu_valid, bus.md_valid, m_alu_pref);
      end
      n_tests++; if (bus.issue_ready !== ((bus.issue_waddr == 0) || (m_cnt[bus.issue_waddr] < 3))) begin
        n_fail++; $display("FAIL random_issue_ready[%0d]: got %b for r%0d with count %0d", c, bus.issue_ready, bus.issue_waddr, m_cnt[bus.issue_waddr]);
      end
      n_tests++; if (bus.chk_pend0 !== exp_pend(bus.chk_raddr0) || bus.chk_pend1 !== exp_pend(bus.chk_raddr1)) begin
        n_fail++; $display("FAIL random_pend[%0d]: got %b%b want %b%b", c, bus.chk_pend0, bus.chk_pend1, exp_pend(bus.chk_raddr0), exp_pend(bus.chk_raddr1));
      end
`ifdef WB_BYPASS_EN
      n_tests++; if (bus.byp_hit0 !== (m_wren && m_waddr == bus.chk_raddr0 && bus.chk_raddr0 != 0) ||
                     bus.byp_hit1 !== (m_wren && m_waddr == bus.chk_raddr1 && bus.chk_raddr1 != 0) ||
                     bus.byp_data0 !== m_wdata || bus.byp_data1 !== m_wdata) begin
        n_fail++; $display("FAIL random_bypass[%0d]: got hit=%b%b data=%h want data=%h", c, bus.byp_hit0, bus.byp_hit1, bus.byp_data0, m_wdata);
      end
`endif
      tick();
      n_tests++; if (bus.rf_wren !== m_wren || bus.rf_waddr !== m_waddr || bus.rf_wdata !== m_wdata) begin
        n_fail++; $display("FAIL random_rf[%0d]: got %b/%0d/%h want %b/%0d/%h", c, bus.rf_wren, bus.rf_waddr, bus.rf_wdata, m_wren, m_waddr, m_wdata);
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_alu_pref = 1'b1; m_wren = 1'b0; m_waddr = '0; m_wdata = '0;
    test_reset();
    test_alu_single();
    test_alternation();
    test_issue_saturate();
    test_r0_write();
    test_same_cycle();
    test_rst_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writeback stage directly upstream of the CPU register file; sole owner of the file's single write port.
- Merges two result producers into one registered write per cycle: single-cycle ALU path and multi-cycle mul/div path.
- Keeps a per-register pending-write scoreboard for the decode/hazard logic.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width (32 registers)
CNT_W, 2, width of each per-register pending counter

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
alu_valid  in  1  ALU result offered
alu_ready  out  1  ALU result accepted this cycle
alu_waddr  in  ADDR_W  ALU destination register
alu_wdata  in  DATA_W  ALU result
md_valid  in  1  mul/div result offered
md_ready  out  1  mul/div result accepted this cycle
md_waddr  in  ADDR_W  mul/div destination register
md_wdata  in  DATA_W  mul/div result
issue_valid  in  1  decode issues an instruction with a destination
issue_ready  out  1  scoreboard can record the issue
issue_waddr  in  ADDR_W  destination of issued instruction
rf_wren  out  1  register file write enable
rf_waddr  out  ADDR_W  register file write address
rf_wdata  out  DATA_W  register file write data
chk_raddr0  in  ADDR_W  hazard query address 0
chk_pend0  out  1  register chk_raddr0 has an outstanding write
chk_raddr1  in  ADDR_W  hazard query address 1
chk_pend1  out  1  register chk_raddr1 has an outstanding write

Behaviour:
- Reset: rf_wren=0, rf_waddr=0, rf_wdata=0, all counters=0, last_grant=MD (so ALU wins the first conflict). issue_ready=1 and chk_pend*=0 in the cycle after reset.
- Arbitration is combinational:
  - Exactly one valid source: it is granted.
  - Both valid: grant the source not equal to last_grant.
  - No valid source: no grant, last_grant unchanged.
  - xx_ready = grant to that source; ready may be low while valid is low. A transfer occurs when valid and ready are both high.
  - last_grant updates on every transfer.
- Output register, 1-cycle latency:
  - On a transfer, rf_waddr and rf_wdata load the granted source's address and data.
  - rf_wren = 1 only if the granted waddr != 0; writes to r0 are accepted and silently dropped.
  - No transfer: rf_wren = 0, rf_waddr and rf_wdata hold their values.
- Register file is always ready; there is no backpressure from downstream.
- Scoreboard: one CNT_W-bit counter per register; register 0 has no counter and always reads 0.
  - Increment on an issue handshake with issue_waddr != 0.
  - Decrement on an edge where rf_wren=1 and rf_waddr selects that register, i.e. the edge on which the file is actually written.
  - Increment and decrement of the same register on the same edge: no change.
  - issue_ready = 0 when the counter of issue_waddr is at max (3); an issue to r0 is always ready.
  - Decrement of a zero counter is a protocol error: the counter stays 0. Under simulation, report it with $display.
- chk_pendN is combinational: (counter[chk_raddrN] != 0); r0 always 0.
- Back-to-back transfers from either source are allowed every cycle; continuous dual-valid traffic alternates strictly between sources.
- rst mid-operation: any write held in rf_* is discarded (rf_wren forced 0), counters clear, and ready behaviour restarts from the reset state.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds outputs byp_hit0/1 (1 bit) and byp_data0/1 (DATA_W).
  - byp_hitN = rf_wren && rf_waddr == chk_raddrN && chk_raddrN != 0; byp_dataN = rf_wdata.
  - chk_pendN is additionally masked low when byp_hitN and counter == 1, so the instruction writing this cycle does not stall decode.
- Undefined: no bypass ports; chk_pendN as specified above.

Decomposition:
- Package cpu_wb_pkg: DATA_W/ADDR_W/CNT_W constants, source enum {SRC_ALU, SRC_MD}, constant REG_ZERO.
- Sub-module wb_scoreboard: the counter array, issue_ready and the chk_pend logic.
- Arbiter and output register remain in the top module.

Test Plan:
- Reset, then alu_valid with waddr=5, wdata=0x1234: alu_ready=1 same cycle; next cycle rf_wren=1, rf_waddr=5, rf_wdata=0x1234.
- Both sources valid for 4 cycles (ALU waddr=1, MD waddr=2): grants ALU, MD, ALU, MD; rf_waddr sequence 1, 2, 1, 2.
- Issue r7 three times: issue_ready falls on the 4th attempt and chk_pend0 (raddr=7) = 1. After three writebacks to r7, chk_pend0 = 0.
- ALU write to r0 with wdata=0xFFFFFFFF: alu_ready=1, rf_wren stays 0, chk_pend for r0 = 0.
- Same-cycle issue to r3 and rf write to r3 with counter=1: counter remains 1 and chk_pend=1.
- Assert rst while rf_wren=1 and counters are nonzero: next cycle rf_wren=0 and all chk_pend=0. With WB_BYPASS_EN, a write to r9 in flight gives byp_hit0=1 and byp_data0=rf_wdata.
